// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage: a 32-step shift-add
// multiply or restoring divide on operand magnitudes, holding the pipeline while it works.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q;
    logic [2:0]        funct3_q;
    logic              neg_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;

    // Issue-cycle decode, evaluated on the live inputs while IDLE.
    logic            is_div, a_signed, b_signed, sign_a, sign_b;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    always_comb begin
        is_div      = funct3[2];
        a_signed    = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        b_signed    = a_signed && (funct3 != 3'b010);
        sign_a      = a_signed && op_a[XLEN-1];
        sign_b      = b_signed && op_b[XLEN-1];
        mag_a       = sign_a ? -op_a : op_a;
        mag_b       = sign_b ? -op_b : op_b;
        div_zero    = is_div && (op_b == '0);
        overflow    = is_div && !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
        special     = div_zero || overflow;
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? op_a : '1;
        else if (overflow)
            special_res = funct3[1] ? '0 : MIN_INT;
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [XLEN:0] diff, sum;

    always_comb begin
        diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        if (funct3_q[2])
            acc_d = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_d = {sum, acc_q[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, calc_res;

    always_comb begin
        prod = neg_q ? -acc_d : acc_d;
        quo  = acc_d[XLEN-1:0];
        rem  = acc_d[2*XLEN-1:XLEN];
        case (funct3_q)
            3'b000:                 calc_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_res = neg_q ? -quo : quo;
            default:                calc_res = neg_q ? -rem : rem;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        funct3_q <= funct3;
                        neg_q    <= (is_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);
                        if (special) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            count_q <= CNT_W'(XLEN);
                            acc_q   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                            opnd_q  <= is_div ? mag_b : mag_a;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q   <= acc_d;
                        count_q <= count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            result_q <= calc_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Combinational so the issuing cycle itself is held.
    assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
    assign busy   = (state_q != IDLE);
    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, busy, valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          ub = longint'({32'h0, b});
        longint unsigned ua = {32'h0, a};
        longint unsigned uu = {32'h0, b};
        longint          p;
        longint unsigned pu;
        logic            ovf = (a == MIN_INT) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = ua * uu; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return MIN_INT;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == MIN_INT && b == 32'hFFFF_FFFF));
    endfunction

    // Issue one op at the start of a cycle (cycle 0) and follow it to its result.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b);
        int          exp_lat = is_special(f3, a, b) ? 1 : 33;
        int          got_lat = -1;
        bit          stall_ok = 1'b1;
        logic [31:0] got_res = 'x;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; flush = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (stall !== (c < exp_lat)) stall_ok = 1'b0;
            if (valid === 1'b1) begin
                got_lat = c;
                got_res = result;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check({tag, " latency"}, 64'(got_lat), 64'(exp_lat));
        check({tag, " result"}, {32'h0, got_res}, {32'h0, ref_model(f3, a, b)});
        check({tag, " stall"}, 64'(stall_ok), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " after_done"}, {62'h0, valid, busy}, 64'h0);
    endtask

    initial begin
        bit saw_valid;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", {29'h0, stall, busy, valid, result}, 64'h0);

        // Directed cases
        do_op("mul_7x-3",  3'b000, 32'd7, 32'hFFFF_FFFD);
        do_op("mulh_min",  3'b001, MIN_INT, MIN_INT);
        do_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("div_-7_2",  3'b100, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_-7_2",  3'b110, 32'hFFFF_FFF9, 32'd2);
        do_op("divu_100_7", 3'b101, 32'd100, 32'd7);
        do_op("remu_100_7", 3'b111, 32'd100, 32'd7);
        do_op("div_by0",   3'b100, 32'd5, 32'd0);
        do_op("remu_by0",  3'b111, 32'd5, 32'd0);
        do_op("div_ovf",   3'b100, MIN_INT, 32'hFFFF_FFFF);
        do_op("rem_ovf",   3'b110, MIN_INT, 32'hFFFF_FFFF);
        do_op("divu_by0",  3'b101, 32'd9, 32'd0);
        do_op("rem_by0",   3'b110, 32'hFFFF_FFF0, 32'd0);

        // Flush at cycle 10 of a DIVU
        saw_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (valid) saw_valid = 1'b1;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        if (valid) saw_valid = 1'b1;
        check("flush_idle", {61'h0, stall, busy, saw_valid}, 64'h0);
        do_op("mul_3x4_after_flush", 3'b000, 32'd3, 32'd4);

        // Reset at cycle 20 of a MUL, with start asserted alongside
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; op_a = 32'd123; op_b = 32'd456;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = (c == 20);
            rst   = (c == 20);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_midop", {29'h0, stall, busy, valid, result}, 64'h0);
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid || busy) saw_valid = 1'b1;
        end
        check("reset_quiet", 64'(saw_valid), 64'h0);

        // start together with flush is ignored
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2;
        @(negedge clk);
        check("start_flush_stall", 64'(stall), 64'h0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("start_flush_busy", {62'h0, busy, valid}, 64'h0);

        // Random operations, biased towards the corner cases
        for (int i = 0; i < 50; i++) begin
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = MIN_INT; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                default: ;
            endcase
            do_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M execution unit and sequencer that sits beside the EX-stage ALU.
- Accepts MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU when control decodes opcode 0110011 with funct7 0000001.
- Computes the result over multiple cycles, stalling the pipeline while it works.
- Presents a one-cycle-valid 32-bit result for EX/MEM capture.
- Handles RISC-V divide-by-zero and signed-overflow cases without iterating.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request: valid RV32M op in EX this cycle.
- funct3  input  3  op select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value.
- flush  input  1  abort the in-flight op (branch/jump redirect).
- stall  output  1  hold IF/ID/EX pipeline registers.
- busy  output  1  unit not in IDLE.
- valid  output  1  result valid, one cycle.
- result  output  XLEN  computed value.

Behaviour:
- Reset: state=IDLE, count=0, internal accumulators=0, valid=0, busy=0, result=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1 and flush=0: latch funct3, op_a, op_b, and operand signs.
  - Load unsigned magnitudes.
  - Special case (DIV*/REM* with op_b=0, or DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF): precompute result and go to DONE.
  - Otherwise: count=XLEN, go to CALC.
- CALC: one iteration per cycle; count decrements; go to DONE when count reaches 1.
- DONE: valid=1 and result driven from register; unconditionally go to IDLE next cycle. start is ignored in DONE.
- Latency (start sampled at cycle 0):
  - Normal op: valid in cycle XLEN+1 (33).
  - Special case: valid in cycle 1.
  - Next start is accepted in the cycle after DONE.
- Stall:
  - stall = (state==IDLE & start & ~flush) | (state==CALC). This is combinational so the issuing cycle is held.
  - stall=0 in DONE, so the pipeline advances and captures result that cycle.
- Multiply:
  - Shift-add on 64-bit product of magnitudes, one multiplier bit per cycle.
  - Negate the product if the operand signs differ and the op is signed (MULH: both signed; MULHSU: only op_a signed; MUL: either sign, same low bits).
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring radix-2 on magnitudes, one quotient bit per cycle.
  - Signed quotient is negated iff the signs differ; signed remainder takes the sign of op_a.
- Special results:
  - Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = op_a.
  - Overflow: DIV = 0x80000000, REM = 0.
- flush: from any state, next state=IDLE, valid=0, no result produced.
  - flush takes priority over start in the same cycle.
  - flush in DONE suppresses nothing already consumed (valid still asserted that cycle).
- Reset mid-operation: identical to the reset values above at the next edge; no valid issued.
- result holds its last value outside DONE. Consumers qualify it with valid only.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD, start one cycle -> stall high cycles 0..32, valid only in cycle 33, result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each valid at cycle 33.
- Special cases, each valid at cycle 1 and stall only in cycle 0:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- DIVU started, flush asserted at cycle 10 -> IDLE at cycle 11, valid never asserted, busy=0. A new MUL 3x4 started at cycle 12 -> result 12 at cycle 45.
- rst asserted at cycle 20 of a MUL -> all outputs 0 next cycle. start in the same cycle as rst is ignored. start in the same cycle as flush is ignored, with stall=0.
